// File: rtl/nano_dbus_bridge.sv
// nano_dbus_bridge: data-side bridge between the nano_rv32i core data port
// and the valid/ready + response-valid system data bus. Stores are lane
// aligned on the way out; loads are lane extracted and sign/zero extended on
// the way back. The core sees a single-cycle ready pulse per request.
module nano_dbus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [31:0]       c_wdata_i,
    input  logic [3:0]        c_rd_i,
    input  logic [3:0]        c_we_i,
    input  logic              c_unsigned_i,
    output logic [31:0]       c_rdata_o,
    output logic              c_ready_o,
    output logic              c_err_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [3:0]        m_we_o,
    output logic [31:0]       m_wdata_o,
    input  logic              m_rvalid_i,
    input  logic [31:0]       m_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        strobe_q, strobe_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        offset_q, offset_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]  strobe;
    logic        req;
    logic        strobe_legal;
    logic        both_dirs;
    logic [1:0]  offset;
    logic [31:0] wdata_aligned;
    logic [CNT_W-1:0] cnt_inc;
    logic        timeout_hit;

    // The two low address bits are implied by the strobes, so the bus never needs them.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^c_addr_i[1:0];

    // Pick the addressed byte/half/word out of the raw bus word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [3:0]  strb,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                extract_load = {{24{~uns & sh[7]}}, sh[7:0]};
            4'b0011, 4'b1100:
                extract_load = {{16{~uns & sh[15]}}, sh[15:0]};
            default:
                extract_load = sh;
        endcase
    endfunction

    // Decode the core request: legality, lane offset and aligned store data.
    always_comb begin
        strobe       = c_rd_i | c_we_i;
        req          = |strobe;
        both_dirs    = (|c_rd_i) & (|c_we_i);
        strobe_legal = 1'b0;
        case (strobe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: strobe_legal = 1'b1;
            default:                   strobe_legal = 1'b0;
        endcase
        if (strobe[0]) begin
            offset = 2'd0;
        end else if (strobe[1]) begin
            offset = 2'd1;
        end else if (strobe[2]) begin
            offset = 2'd2;
        end else begin
            offset = 2'd3;
        end
        wdata_aligned = c_wdata_i << {offset, 3'b000};
    end

    // Saturating timeout counter increment and expiry test.
    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
    end

    // Next-state logic: request capture, bus handshake, response and timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        strobe_d   = strobe_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        unsigned_d = unsigned_q;
        offset_d   = offset_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    rdata_d = '0;
                    if (!strobe_legal || both_dirs) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        err_d      = 1'b0;
                        addr_d     = {c_addr_i[ADDR_W-1:2], 2'b00};
                        strobe_d   = strobe;
                        we_d       = c_we_i;
                        is_write_d = |c_we_i;
                        unsigned_d = c_unsigned_i;
                        offset_d   = offset;
                        wdata_d    = (|c_we_i) ? wdata_aligned : '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (m_ready_i) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (m_rvalid_i) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rdata_d = is_write_q ? 32'd0
                                         : extract_load(m_rdata_i, strobe_q, offset_q, unsigned_q);
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            strobe_q   <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            unsigned_q <= 1'b0;
            offset_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            strobe_q   <= strobe_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            unsigned_q <= unsigned_d;
            offset_q   <= offset_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are decoded from state so they are zero outside their phase.
    always_comb begin
        m_valid_o = 1'b0;
        m_addr_o  = '0;
        m_we_o    = '0;
        m_wdata_o = '0;
        c_ready_o = 1'b0;
        c_err_o   = 1'b0;
        c_rdata_o = '0;
        case (state_q)
            S_REQ: begin
                m_valid_o = 1'b1;
                m_addr_o  = addr_q;
                m_we_o    = we_q;
                m_wdata_o = wdata_q;
            end
            S_DONE: begin
                c_ready_o = 1'b1;
                c_err_o   = err_q;
                c_rdata_o = rdata_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_nano_dbus_bridge.sv
// Directed self-checking bench for nano_dbus_bridge with a small bus
// responder that can stall acceptance, delay or withhold the response.
module tb_nano_dbus_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] c_addr_i;
    logic [31:0] c_wdata_i;
    logic [3:0]  c_rd_i;
    logic [3:0]  c_we_i;
    logic        c_unsigned_i;
    logic [31:0] c_rdata_o;
    logic        c_ready_o;
    logic        c_err_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_addr_o;
    logic [3:0]  m_we_o;
    logic [31:0] m_wdata_o;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    int errors = 0;
    int checks = 0;

    int          stallLeft   = 0;
    logic        respEnable  = 1'b1;
    logic        forceRvalid = 1'b0;
    logic [31:0] respData    = 32'd0;
    logic        acceptedFlag = 1'b0;

    nano_dbus_bridge #(
        .TIMEOUT_CYCLES(8),
        .ADDR_W        (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .c_addr_i    (c_addr_i),
        .c_wdata_i   (c_wdata_i),
        .c_rd_i      (c_rd_i),
        .c_we_i      (c_we_i),
        .c_unsigned_i(c_unsigned_i),
        .c_rdata_o   (c_rdata_o),
        .c_ready_o   (c_ready_o),
        .c_err_o     (c_err_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_addr_o    (m_addr_o),
        .m_we_o      (m_we_o),
        .m_wdata_o   (m_wdata_o),
        .m_rvalid_i  (m_rvalid_i),
        .m_rdata_i   (m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Remember whether a request was accepted on this edge.
    always @(posedge clk_i) begin
        acceptedFlag <= m_valid_o & m_ready_i;
    end

    // Bus responder: stalls acceptance for stallLeft cycles, answers one cycle after accept.
    always @(negedge clk_i) begin
        m_rdata_i  = respData;
        m_rvalid_i = (acceptedFlag & respEnable) | forceRvalid;
        if (m_valid_o) begin
            if (stallLeft > 0) begin
                m_ready_i = 1'b0;
                stallLeft = stallLeft - 1;
            end else begin
                m_ready_i = 1'b1;
            end
        end else begin
            m_ready_i = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] rd, input logic [3:0] we, input logic uns);
        c_addr_i     = addr;
        c_wdata_i    = wdata;
        c_rd_i       = rd;
        c_we_i       = we;
        c_unsigned_i = uns;
    endtask

    // Clock until the completion pulse, recording latency and the first bus request seen.
    task automatic waitReady(input int maxCycles, output int cycles, output logic [31:0] rdata,
                             output logic err, output logic sawValid, output logic [31:0] addr,
                             output logic [3:0] we, output logic [31:0] wdata);
        cycles = 0; rdata = '0; err = 1'b0; sawValid = 1'b0;
        addr = '0; we = '0; wdata = '0;
        while (cycles < maxCycles) begin
            tick();
            cycles++;
            if (m_valid_o && !sawValid) begin
                sawValid = 1'b1;
                addr     = m_addr_o;
                we       = m_we_o;
                wdata    = m_wdata_o;
            end
            if (c_ready_o) begin
                rdata = c_rdata_o;
                err   = c_err_o;
                applyStimulus(32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
                return;
            end
        end
        checkOutput("readyBudget", {31'd0, c_ready_o}, 32'd1);
        applyStimulus(32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
    endtask

    // Run a load with a zero-wait bus and check result, error and 3-cycle latency.
    task automatic runLoad(input string tag, input logic [31:0] addr, input logic [3:0] rd,
                           input logic uns, input logic [31:0] busWord, input logic [31:0] expData);
        int cyc; logic [31:0] rdv; logic e; logic sv; logic [31:0] a; logic [3:0] w; logic [31:0] wd;
        respData = busWord;
        applyStimulus(addr, 32'd0, rd, 4'd0, uns);
        waitReady(20, cyc, rdv, e, sv, a, w, wd);
        checkOutput({tag, ".rdata"}, rdv, expData);
        checkOutput({tag, ".err"}, {31'd0, e}, 32'd0);
        checkOutput({tag, ".latency"}, cyc, 32'd3);
        checkOutput({tag, ".maddr"}, a, {addr[31:2], 2'b00});
        checkOutput({tag, ".mwe"}, {28'd0, w}, 32'd0);
        tick();
        checkOutput({tag, ".pulseEnd"}, {31'd0, c_ready_o}, 32'd0);
    endtask

    // Run an illegal request: error completion on the next cycle with no bus request.
    task automatic runIllegal(input string tag, input logic [3:0] rd, input logic [3:0] we);
        int cyc; logic [31:0] rdv; logic e; logic sv; logic [31:0] a; logic [3:0] w; logic [31:0] wd;
        applyStimulus(32'h0000_0700, 32'hFFFF_FFFF, rd, we, 1'b0);
        waitReady(20, cyc, rdv, e, sv, a, w, wd);
        checkOutput({tag, ".latency"}, cyc, 32'd1);
        checkOutput({tag, ".err"}, {31'd0, e}, 32'd1);
        checkOutput({tag, ".rdata"}, rdv, 32'd0);
        checkOutput({tag, ".noValid"}, {31'd0, sv}, 32'd0);
        tick();
        checkOutput({tag, ".pulseEnd"}, {31'd0, c_ready_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc; logic [31:0] rdv; logic e; logic sv; logic [31:0] a; logic [3:0] w; logic [31:0] wd;
        logic anyReady;

        rst_n_i    = 1'b0;
        m_ready_i  = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'd0;
        applyStimulus(32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        #1;
        checkOutput("reset.ready", {31'd0, c_ready_o}, 32'd0);
        checkOutput("reset.err", {31'd0, c_err_o}, 32'd0);
        checkOutput("reset.rdata", c_rdata_o, 32'd0);
        checkOutput("reset.mvalid", {31'd0, m_valid_o}, 32'd0);
        checkOutput("reset.mbus", m_addr_o | m_wdata_o | {28'd0, m_we_o}, 32'd0);
        repeat (2) tick();
        rst_n_i = 1'b1;
        tick();

        // Loads with a zero-wait bus.
        runLoad("wordLoad", 32'h0000_0100, 4'b1111, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        runLoad("byteSigned", 32'h0000_0103, 4'b1000, 1'b0, 32'h8011_2233, 32'hFFFF_FF80);
        runLoad("byteUnsigned", 32'h0000_0103, 4'b1000, 1'b1, 32'h8011_2233, 32'h0000_0080);
        runLoad("byteLane1", 32'h0000_0101, 4'b0010, 1'b0, 32'h8011_2233, 32'h0000_0022);
        runLoad("halfSigned", 32'h0000_0102, 4'b1100, 1'b0, 32'h8011_2233, 32'hFFFF_8011);
        runLoad("halfUnsigned", 32'h0000_0102, 4'b1100, 1'b1, 32'h8011_2233, 32'h0000_8011);

        // Half store: lane-aligned data and enables, zero load data on completion.
        respData = 32'h1234_5678;
        applyStimulus(32'h0000_0202, 32'h0000_ABCD, 4'd0, 4'b1100, 1'b0);
        waitReady(20, cyc, rdv, e, sv, a, w, wd);
        checkOutput("halfStore.maddr", a, 32'h0000_0200);
        checkOutput("halfStore.mwe", {28'd0, w}, 32'h0000_000C);
        checkOutput("halfStore.mwdata", wd, 32'hABCD_0000);
        checkOutput("halfStore.rdata", rdv, 32'd0);
        checkOutput("halfStore.err", {31'd0, e}, 32'd0);
        checkOutput("halfStore.latency", cyc, 32'd3);
        tick();

        // Backpressure: bus refuses for 5 cycles; request must stay put for all 6.
        stallLeft = 5;
        applyStimulus(32'h0000_0305, 32'h0000_00A5, 4'd0, 4'b0010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("bp%0d.mvalid", i), {31'd0, m_valid_o}, 32'd1);
            checkOutput($sformatf("bp%0d.maddr", i), m_addr_o, 32'h0000_0304);
            checkOutput($sformatf("bp%0d.mwe", i), {28'd0, m_we_o}, 32'h0000_0002);
            checkOutput($sformatf("bp%0d.mwdata", i), m_wdata_o, 32'h0000_A500);
            checkOutput($sformatf("bp%0d.ready", i), {31'd0, c_ready_o}, 32'd0);
        end
        waitReady(20, cyc, rdv, e, sv, a, w, wd);
        checkOutput("bp.tailLatency", cyc, 32'd2);
        checkOutput("bp.err", {31'd0, e}, 32'd0);
        tick();
        checkOutput("bp.pulseEnd", {31'd0, c_ready_o}, 32'd0);

        // Illegal strobe patterns.
        runIllegal("illegal0101", 4'b0101, 4'b0000);
        runIllegal("illegalRdWe", 4'b0001, 4'b0001);

        // Timeout: response withheld, error completion 8 cycles after entering REQ.
        respEnable = 1'b0;
        applyStimulus(32'h0000_0400, 32'd0, 4'b1111, 4'd0, 1'b0);
        waitReady(30, cyc, rdv, e, sv, a, w, wd);
        checkOutput("timeout.latency", cyc, 32'd9);
        checkOutput("timeout.err", {31'd0, e}, 32'd1);
        checkOutput("timeout.rdata", rdv, 32'd0);
        checkOutput("timeout.mvalid", {31'd0, m_valid_o}, 32'd0);
        tick();
        forceRvalid = 1'b1;
        tick();
        forceRvalid = 1'b0;
        checkOutput("lateRvalid.ready", {31'd0, c_ready_o}, 32'd0);
        tick();
        checkOutput("lateRvalid.ready2", {31'd0, c_ready_o}, 32'd0);
        checkOutput("lateRvalid.mvalid", {31'd0, m_valid_o}, 32'd0);

        // Reset asserted while waiting for a response.
        applyStimulus(32'h0000_0500, 32'd0, 4'b1111, 4'd0, 1'b0);
        tick();
        tick();
        checkOutput("rstWait.inWait", {31'd0, m_valid_o}, 32'd0);
        rst_n_i = 1'b0;
        applyStimulus(32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        #1;
        checkOutput("rstWait.ready", {31'd0, c_ready_o}, 32'd0);
        checkOutput("rstWait.err", {31'd0, c_err_o}, 32'd0);
        checkOutput("rstWait.rdata", c_rdata_o, 32'd0);
        checkOutput("rstWait.mvalid", {31'd0, m_valid_o}, 32'd0);
        checkOutput("rstWait.mbus", m_addr_o | m_wdata_o | {28'd0, m_we_o}, 32'd0);
        #2;
        rst_n_i = 1'b1;
        respEnable = 1'b1;
        anyReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            anyReady = anyReady | c_ready_o | m_valid_o;
        end
        checkOutput("rstWait.quiet", {31'd0, anyReady}, 32'd0);
        runLoad("postReset", 32'h0000_0600, 4'b0011, 1'b0, 32'h0000_7FFF, 32'h0000_7FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
